// File: rtl/sc_pkg.sv
// -----------------------------------------------------------------------------
// sc_pkg
// Shared definitions for the stochastic-computing arithmetic engine:
//   - operation mode encodings
//   - FSM state encoding
//   - LFSR geometry (width, feedback taps, default seed)
//   - stream bit offset used to decorrelate operand B from operand A
//   - helper functions for the LFSR step and the per-mode operator bit
// -----------------------------------------------------------------------------
package sc_pkg;

  // Operation modes
  localparam logic [1:0] SC_MODE_MUL  = 2'b00;  // bipolar multiply (XNOR)
  localparam logic [1:0] SC_MODE_ADD  = 2'b01;  // scaled add (MUX on LFSR msb)
  localparam logic [1:0] SC_MODE_SMUL = 2'b10;  // bipolar self-multiply of A
  localparam logic [1:0] SC_MODE_AND  = 2'b11;  // unipolar multiply (AND)

  // Engine states
  typedef enum logic [1:0] {
    SC_IDLE = 2'b00,
    SC_RUN  = 2'b01,
    SC_DONE = 2'b10
  } sc_state_e;

  // LFSR geometry
  localparam int unsigned SC_LFSR_W      = 31;
  localparam int unsigned SC_LFSR_TAP_LO = 27;
  localparam int unsigned SC_LFSR_TAP_HI = 30;
  localparam logic [SC_LFSR_W-1:0] SC_DEFAULT_SEED = 31'd1349395;

  // Operand B compares against LFSR bits starting here, so the two streams
  // draw on disjoint bit fields of the same register.
  localparam int unsigned SC_SB_OFFSET = 12;

  // One Fibonacci step: shift left, feedback enters at bit 0.
  function automatic logic [SC_LFSR_W-1:0] sc_lfsr_next(input logic [SC_LFSR_W-1:0] s);
    sc_lfsr_next = {s[SC_LFSR_W-2:0], s[SC_LFSR_TAP_LO] ^ s[SC_LFSR_TAP_HI]};
  endfunction

  // Stochastic operator output bit for the selected mode.
  //   sa/sb : operand stream bits, sel : mux select, dly : previous sa
  function automatic logic sc_op_bit(input logic [1:0] m,
                                     input logic       sa,
                                     input logic       sb,
                                     input logic       sel,
                                     input logic       dly);
    case (m)
      SC_MODE_MUL:  sc_op_bit = ~(sa ^ sb);
      SC_MODE_ADD:  sc_op_bit = sel ? sb : sa;
      SC_MODE_SMUL: sc_op_bit = ~(sa ^ dly);
      SC_MODE_AND:  sc_op_bit = sa & sb;
      default:      sc_op_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sc_arith_engine_lfsr.sv
// -----------------------------------------------------------------------------
// sc_lfsr31
// Free-running 31-bit Fibonacci LFSR (feedback = bit27 ^ bit30, shifted left
// every cycle). It is never re-seeded between transactions; only the
// asynchronous reset loads SEED.
// Ports:
//   clk     : clock
//   rst_n   : asynchronous reset, active-high (legacy name kept)
//   o_lfsr  : current LFSR state
// -----------------------------------------------------------------------------
module sc_lfsr31
  import sc_pkg::*;
#(
  parameter logic [SC_LFSR_W-1:0] SEED = SC_DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [SC_LFSR_W-1:0] o_lfsr
);

  logic [SC_LFSR_W-1:0] r_lfsr;

  // LFSR state register, advances every cycle in every engine state
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= sc_lfsr_next(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/sc_arith_engine.sv
// -----------------------------------------------------------------------------
// sc_arith_engine
// Stochastic-computing arithmetic engine. One operand pair and a mode are
// accepted per transaction; both operands are turned into bitstreams by
// comparison against a shared free-running LFSR, the selected operator runs
// for 2^LEN_LOG2 cycles, and the ones-count (scaled to WIDTH bits, saturating)
// is returned through a valid/ready handshake.
//
// Parameters:
//   WIDTH     : operand/result width, 4..12
//   LEN_LOG2  : log2 of stream length, WIDTH..24
//   LFSR_SEED : LFSR reset value, nonzero
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-high reset
//   in_valid/in_ready : operand handshake (in_ready high only in IDLE)
//   op_a, op_b, mode  : operands and operation, sampled on the accept edge
//   out_valid/out_ready : result handshake
//   result            : scaled ones-count, held until consumed
//   busy              : high in RUN or DONE
//   abort             : (only with SC_ABORT_EN) abandons a RUN in progress
//
// Build option: define SC_ABORT_EN to add the abort input.
// -----------------------------------------------------------------------------
module sc_arith_engine
  import sc_pkg::*;
#(
  parameter int unsigned          WIDTH     = 9,
  parameter int unsigned          LEN_LOG2  = 17,
  parameter logic [SC_LFSR_W-1:0] LFSR_SEED = SC_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef SC_ABORT_EN
  ,
  input  logic             abort
`endif
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  sc_state_e              r_state;
  sc_state_e              w_state_nxt;

  logic [WIDTH-1:0]       r_op_a;
  logic [WIDTH-1:0]       r_op_b;
  logic [1:0]             r_mode;

  logic [LEN_LOG2-1:0]    r_cyc_cnt;
  logic [LEN_LOG2:0]      r_ones_cnt;   // one extra bit: a full stream of ones fits
  logic                   r_delay;

  logic [WIDTH-1:0]       r_result;
  logic                   r_out_valid;
  logic                   r_in_ready;
  logic                   r_busy;

  logic [SC_LFSR_W-1:0]   w_lfsr;
  logic [WIDTH-1:0]       w_lfsr_lo;
  logic [WIDTH-1:0]       w_lfsr_hi;
  logic                   w_sa;
  logic                   w_sb;
  logic                   w_sel;
  logic                   w_op_bit;
  logic                   w_last;
  logic [LEN_LOG2:0]      w_ones_final;
  logic [WIDTH-1:0]       w_result_final;
  logic                   w_abort;

  logic                   w_accept;
  logic                   w_finish;
  logic                   w_in_ready_nxt;
  logic                   w_busy_nxt;
  logic                   w_out_valid_nxt;

  // ---------------------------------------------------------------------------
  // Random source
  // ---------------------------------------------------------------------------
  sc_lfsr31 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_lfsr (w_lfsr)
  );

`ifdef SC_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stream generation and operator
  // ---------------------------------------------------------------------------
  // Low field drives operand A, the field starting at SC_SB_OFFSET drives B.
  assign w_lfsr_lo = WIDTH'(w_lfsr);
  assign w_lfsr_hi = WIDTH'(w_lfsr >> SC_SB_OFFSET);
  assign w_sel     = w_lfsr[SC_LFSR_TAP_HI];

  assign w_sa      = (w_lfsr_lo < r_op_a);
  assign w_sb      = (w_lfsr_hi < r_op_b);
  assign w_op_bit  = sc_op_bit(r_mode, w_sa, w_sb, w_sel, r_delay);

  assign w_last       = (r_cyc_cnt == {LEN_LOG2{1'b1}});
  assign w_ones_final = r_ones_cnt + {{LEN_LOG2{1'b0}}, w_op_bit};

  // Only a stream of all ones reaches the top bit; it saturates the result
  // instead of wrapping the scaled field back to zero.
  assign w_result_final = w_ones_final[LEN_LOG2] ? {WIDTH{1'b1}}
                                                  : w_ones_final[LEN_LOG2-1 -: WIDTH];

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  // Next-state and transaction strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      SC_IDLE: begin
        if (in_valid) begin
          w_state_nxt = SC_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = SC_IDLE;
        end
      end
      SC_RUN: begin
        if (w_abort) begin
          w_state_nxt = SC_IDLE;
        end else if (w_last) begin
          w_state_nxt = SC_DONE;
          w_finish    = 1'b1;
        end else begin
          w_state_nxt = SC_RUN;
        end
      end
      SC_DONE: begin
        // Leave only once the consumer has seen a presented result.
        if (r_out_valid && out_ready) begin
          w_state_nxt = SC_IDLE;
        end else begin
          w_state_nxt = SC_DONE;
        end
      end
      default: begin
        w_state_nxt = SC_IDLE;
      end
    endcase
  end

  // Registered-output next values, derived from the state being entered.
  // out_valid is set only once DONE has already been entered, which places
  // its rising edge one cycle after the final stream bit is counted.
  always_comb begin
    w_in_ready_nxt  = (w_state_nxt == SC_IDLE);
    w_busy_nxt      = (w_state_nxt != SC_IDLE);
    w_out_valid_nxt = (r_state == SC_DONE) && (w_state_nxt == SC_DONE);
  end

  // State register and handshake/status outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= SC_IDLE;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Operand/mode capture, only on the accept edge
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_op_a <= {WIDTH{1'b0}};
      r_op_b <= {WIDTH{1'b0}};
      r_mode <= SC_MODE_MUL;
    end else if (w_accept) begin
      r_op_a <= op_a;
      r_op_b <= op_b;
      r_mode <= mode;
    end
  end

  // Cycle/ones counters and the one-cycle delay of stream A
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_cyc_cnt  <= {LEN_LOG2{1'b0}};
      r_ones_cnt <= {(LEN_LOG2+1){1'b0}};
      r_delay    <= 1'b0;
    end else if (w_accept) begin
      r_cyc_cnt  <= {LEN_LOG2{1'b0}};
      r_ones_cnt <= {(LEN_LOG2+1){1'b0}};
      r_delay    <= 1'b0;
    end else if (r_state == SC_RUN) begin
      r_cyc_cnt  <= r_cyc_cnt + LEN_LOG2'(1);
      r_ones_cnt <= w_ones_final;
      r_delay    <= w_sa;
    end
  end

  // Result register, loaded with the final count as RUN completes
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_result <= {WIDTH{1'b0}};
    end else if (w_finish) begin
      r_result <= w_result_final;
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule

// File: tb/tb_sc_arith_engine.sv
// -----------------------------------------------------------------------------
// tb_sc_arith_engine
// Scoreboard bench for sc_arith_engine with a shortened stream (LEN_LOG2=10).
// The driver pushes the expected result of each accepted transaction, obtained
// from a plain-arithmetic model that walks the stream from the LFSR value seen
// at acceptance; a separate monitor pops and compares when results are taken.
// -----------------------------------------------------------------------------
module tb_sc_arith_engine;

  localparam int WIDTH    = 9;
  localparam int LEN_LOG2 = 10;
  localparam int N        = 1 << LEN_LOG2;
  localparam logic [30:0] SEED = 31'd1349395;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;
`ifdef SC_ABORT_EN
  logic             abort;
`endif

  always #5 clk = ~clk;

  sc_arith_engine #(
    .WIDTH     (WIDTH),
    .LEN_LOG2  (LEN_LOG2),
    .LFSR_SEED (SEED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef SC_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     hold = 1'b0;

  typedef struct {
    int     exp;
    longint acc;
  } txn_t;
  txn_t sb_q[$];

  // Reference LFSR sequence, tracked independently of the design.
  logic [30:0] m_lfsr;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[29:0], m_lfsr[27] ^ m_lfsr[30]};
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result: run N stream bits from LFSR state s0 and scale the count.
  function automatic int model(input logic [30:0] s0, input int a, input int b, input int m);
    logic [30:0] s;
    int ones, lo, hi, r;
    bit sa, sb, sel, d, bt;
    s = s0; ones = 0; d = 1'b0;
    for (int k = 0; k < N; k++) begin
      lo  = int'(s) % (1 << WIDTH);
      hi  = (int'(s) >> 12) % (1 << WIDTH);
      sel = s[30];
      sa  = (lo < a);
      sb  = (hi < b);
      case (m)
        0:       bt = (sa == sb);
        1:       bt = sel ? sb : sa;
        2:       bt = (sa == d);
        default: bt = sa && sb;
      endcase
      ones += int'(bt);
      d = sa;
      s = {s[29:0], s[27] ^ s[30]};
    end
    r = ones >> (LEN_LOG2 - WIDTH);
    if (r > (1 << WIDTH) - 1) r = (1 << WIDTH) - 1;
    return r;
  endfunction

  // Issue one transaction; fixed_exp >= 0 overrides the model with a known value.
  task automatic send(input int a, input int b, input int m, input int fixed_exp);
    int   w;
    txn_t t;
    w = 0;
    while (!in_ready && w < 5000) begin
      @(posedge clk); #2;
      w++;
    end
    chk("accept_timeout", longint'(in_ready), 1);
    if (in_ready) begin
      op_a = WIDTH'(a); op_b = WIDTH'(b); mode = 2'(m); in_valid = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); mode = 2'($urandom);
      t.acc = cyc;
      t.exp = (fixed_exp >= 0) ? fixed_exp : model(m_lfsr, a, b, m);
      sb_q.push_back(t);
      chk("busy_run", longint'(busy), 1);
      chk("in_ready_run", longint'(in_ready), 0);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() > 0 && w < 5000) begin
      @(posedge clk); #2;
      w++;
    end
    chk("drain_pending", sb_q.size(), 0);
  endtask

  // Consumer ready: random, or held low while 'hold' is set.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency, DONE-phase stability and scoreboard comparison.
  initial begin
    bit               pov, phs;
    logic [WIDTH-1:0] held;
    txn_t             t;
    pov = 1'b0; phs = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b0) begin
        pov = 1'b0; phs = 1'b0;
      end else begin
        if (phs) begin
          chk("out_valid_drop", longint'(out_valid), 0);
          chk("in_ready_back", longint'(in_ready), 1);
        end
        if (out_valid && !pov) begin
          chk("expected_pending", longint'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) chk("latency", cyc - sb_q[0].acc, N + 1);
          held = result;
        end
        if (out_valid) begin
          if (pov) chk("result_stable", longint'(result), longint'(held));
          chk("in_ready_done", longint'(in_ready), 0);
          chk("busy_done", longint'(busy), 1);
        end
        phs = out_valid && out_ready;
        if (phs && sb_q.size() > 0) begin
          t = sb_q.pop_front();
          chk("result", longint'(result), t.exp);
        end
        pov = out_valid;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [WIDTH-1:0] res_before;
    in_valid = 1'b0; op_a = '0; op_b = '0; mode = 2'b00;
`ifdef SC_ABORT_EN
    abort = 1'b0;
`endif
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_result", longint'(result), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_in_ready", longint'(in_ready), 1);
    rst_n = 1'b0;
    @(posedge clk); #2;

    // Directed: saturation, zero, typical products/sum, self-mul, back-to-back
    send(0,   0,   0, 511);
    send(256, 256, 3, -1);
    send(0,   511, 3, 0);
    send(384, 384, 0, -1);
    send(0,   510, 1, -1);
    send(384, 0,   2, -1);
    send(256, 256, 3, -1);
    drain();

    // Consumer stalls in DONE while in_valid pulses are offered
    hold = 1'b1;
    send(100, 200, 0, -1);
    w = 0;
    while (!out_valid && w < 3000) begin
      @(posedge clk); #2;
      w++;
    end
    chk("stall_reached_done", longint'(out_valid), 1);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      in_valid = 1'(($urandom_range(0, 1)));
      op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); mode = 2'($urandom);
    end
    in_valid = 1'b0;
    hold = 1'b0;
    drain();

    // Randomized transactions
    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, (1 << WIDTH) - 1)),
           int'($urandom_range(0, (1 << WIDTH) - 1)),
           int'($urandom_range(0, 3)), -1);
    end
    drain();

    // Asynchronous reset in the middle of RUN
    send(300, 150, 3, -1);
    repeat (500) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("midrun_out_valid", longint'(out_valid), 0);
    chk("midrun_result", longint'(result), 0);
    chk("midrun_busy", longint'(busy), 0);
    chk("midrun_in_ready", longint'(in_ready), 1);
    sb_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    send(200, 400, 1, -1);
    drain();

`ifdef SC_ABORT_EN
    // Abort part-way through RUN: back to IDLE, no result, result unchanged
    res_before = result;
    send(123, 321, 0, -1);
    repeat (100) @(posedge clk);
    #2;
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    sb_q.delete();
    chk("abort_in_ready", longint'(in_ready), 1);
    chk("abort_busy", longint'(busy), 0);
    repeat (N + 20) @(posedge clk);
    #2;
    chk("abort_result_kept", longint'(result), longint'(res_before));
    send(50, 60, 3, -1);
    drain();
`else
    res_before = result;
    chk("final_result_held", longint'(result), longint'(res_before));
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
